// File: rtl/uart_cmd_pkg.sv
// Shared constants, state type and byte-decode helpers for the UART command decoder.
// Optional build macro UART_CMD_CASE_FOLD_EN is consumed by uart_cmd_dec.
package uart_cmd_pkg;

   localparam int unsigned NUM_PULSE = 8;
   localparam int unsigned NUM_MODE  = 5;

   localparam logic [7:0] CODE_ARG = 8'h56;
   localparam logic [7:0] CODE_CR  = 8'h0D;
   localparam logic [7:0] CODE_ESC = 8'h1B;

   localparam logic [7:0] CODE_U = 8'h55;
   localparam logic [7:0] CODE_D = 8'h44;
   localparam logic [7:0] CODE_R = 8'h52;
   localparam logic [7:0] CODE_L = 8'h4C;
   localparam logic [7:0] CODE_G = 8'h47;
   localparam logic [7:0] CODE_S = 8'h53;
   localparam logic [7:0] CODE_C = 8'h43;

   localparam logic [7:0] CODE_M = 8'h4D;
   localparam logic [7:0] CODE_N = 8'h4E;
   localparam logic [7:0] CODE_T = 8'h54;
   localparam logic [7:0] CODE_I = 8'h49;
   localparam logic [7:0] CODE_H = 8'h48;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ARG  = 1'b1
   } state_t;

   // One-hot pulse channel for a command byte; zero when the byte is not a pulse code.
   function automatic logic [NUM_PULSE-1:0] pulse_onehot(input logic [7:0] code);
      logic [NUM_PULSE-1:0] hit;
      hit = '0;
      case (code)
         CODE_U:   hit[0] = 1'b1;
         CODE_D:   hit[1] = 1'b1;
         CODE_R:   hit[2] = 1'b1;
         CODE_L:   hit[3] = 1'b1;
         CODE_G:   hit[4] = 1'b1;
         CODE_S:   hit[5] = 1'b1;
         CODE_C:   hit[6] = 1'b1;
         CODE_ESC: hit[7] = 1'b1;
         default:  hit = '0;
      endcase
      return hit;
   endfunction

   // One-hot mode toggle for a command byte; zero when the byte is not a toggle code.
   function automatic logic [NUM_MODE-1:0] mode_onehot(input logic [7:0] code);
      logic [NUM_MODE-1:0] hit;
      hit = '0;
      case (code)
         CODE_M:  hit[0] = 1'b1;
         CODE_N:  hit[1] = 1'b1;
         CODE_T:  hit[2] = 1'b1;
         CODE_I:  hit[3] = 1'b1;
         CODE_H:  hit[4] = 1'b1;
         default: hit = '0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/uart_cmd_pulse_stretch.sv
// Single pulse channel: a load (re)starts a PULSE_LEN-cycle registered pulse.
module uart_cmd_pulse_stretch #(
   parameter int unsigned PULSE_LEN = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic active
);

   localparam int unsigned CW = (PULSE_LEN < 1) ? 1 : $clog2(PULSE_LEN + 1);

   logic [CW-1:0] cnt;

   // Output stays high while more than one cycle of the pulse remains after this edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt    <= '0;
         active <= 1'b0;
      end else if (load) begin
         cnt    <= CW'(PULSE_LEN);
         active <= 1'b1;
      end else begin
         active <= (cnt > CW'(1));
         if (cnt != '0) cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/uart_cmd_dec.sv
// UART command decoder: pulses, mode toggles and a decimal argument with timeout.
// Build macro UART_CMD_CASE_FOLD_EN folds lowercase letters to uppercase before decoding.
module uart_cmd_dec
   import uart_cmd_pkg::*;
#(
   parameter int unsigned PULSE_LEN   = 1,
   parameter int unsigned ARG_W       = 10,
   parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_done,
   input  logic [7:0]           rx_data,
   output logic [NUM_PULSE-1:0] pulse,
   output logic [NUM_MODE-1:0]  mode,
   output logic [ARG_W-1:0]     arg_data,
   output logic                 arg_valid,
   output logic                 cmd_err
);

   localparam int unsigned ACC_W = ARG_W + 4;
   localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [ACC_W-1:0] ACC_MAX  = ACC_W'((32'd1 << ARG_W) - 32'd1);
   localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYC - 1);

   state_t               state;
   logic [ACC_W-1:0]     acc;
   logic [2:0]           digits;
   logic [TW-1:0]        tmo;

   logic [7:0]           code;
   logic [NUM_PULSE-1:0] pulse_hit;
   logic [NUM_MODE-1:0]  mode_hit;
   logic [NUM_PULSE-1:0] load;
   logic                 is_digit;
   logic [ACC_W-1:0]     acc_sum;
   logic [ACC_W-1:0]     acc_next;

   // Byte normalisation and decode.
   always_comb begin
      code = rx_data;
`ifdef UART_CMD_CASE_FOLD_EN
      if (rx_data >= 8'h61 && rx_data <= 8'h7A) code = rx_data - 8'h20;
`endif
      pulse_hit = pulse_onehot(code);
      mode_hit  = mode_onehot(code);
      is_digit  = (code >= 8'h30) && (code <= 8'h39);
      acc_sum   = (acc * ACC_W'(10)) + ACC_W'(code[3:0]);
      acc_next  = (acc_sum > ACC_MAX) ? ACC_MAX : acc_sum;
      load      = '0;
      if (rx_done && (state == ST_IDLE || code == CODE_ESC)) load = pulse_hit;
   end

   for (genvar i = 0; i < NUM_PULSE; i++) begin : g_pulse
      uart_cmd_pulse_stretch #(
         .PULSE_LEN(PULSE_LEN)
      ) u_stretch (
         .clk   (clk),
         .rst   (rst),
         .load  (load[i]),
         .active(pulse[i])
      );
   end

   // Command FSM with registered mode/argument/strobe outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         acc       <= '0;
         digits    <= '0;
         tmo       <= '0;
         mode      <= '0;
         arg_data  <= '0;
         arg_valid <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         arg_valid <= 1'b0;
         cmd_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               tmo <= '0;
               if (rx_done) begin
                  if (code == CODE_ARG) begin
                     acc    <= '0;
                     digits <= '0;
                     state  <= ST_ARG;
                  end else if (|mode_hit) begin
                     mode <= mode ^ mode_hit;
                  end else if (pulse_hit == '0) begin
                     cmd_err <= 1'b1;
                  end
               end
            end
            ST_ARG: begin
               if (rx_done) begin
                  tmo <= '0;
                  if (code == CODE_ESC) begin
                     acc    <= '0;
                     digits <= '0;
                     state  <= ST_IDLE;
                  end else if (is_digit) begin
                     acc <= acc_next;
                     if (digits != 3'd7) digits <= digits + 3'd1;
                  end else if (code == CODE_CR && digits != '0) begin
                     arg_data  <= acc[ARG_W-1:0];
                     arg_valid <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     cmd_err <= 1'b1;
                     state   <= ST_IDLE;
                  end
               end else if (tmo == TMO_LAST) begin
                  // Argument abandoned: arg_data keeps its last accepted value.
                  cmd_err <= 1'b1;
                  tmo     <= '0;
                  state   <= ST_IDLE;
               end else begin
                  tmo <= tmo + TW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_dec.sv
// Directed bench for uart_cmd_dec with PULSE_LEN=3, ARG_W=10, TIMEOUT_CYC=50.
module tb_uart_cmd_dec;

   logic       clk;
   logic       rst;
   logic       rx_done;
   logic [7:0] rx_data;
   logic [7:0] pulse;
   logic [4:0] mode;
   logic [9:0] arg_data;
   logic       arg_valid;
   logic       cmd_err;

   int checks = 0;
   int errors = 0;

   uart_cmd_dec #(
      .PULSE_LEN  (3),
      .ARG_W      (10),
      .TIMEOUT_CYC(50)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_done  (rx_done),
      .rx_data  (rx_data),
      .pulse    (pulse),
      .mode     (mode),
      .arg_data (arg_data),
      .arg_valid(arg_valid),
      .cmd_err  (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // Present one byte for one cycle; returns at the negedge where its response is visible.
   task automatic drive(input logic [7:0] b);
      rx_done = 1'b1;
      rx_data = b;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   int err_seen;
   int err_first;

   initial begin
      rst     = 1'b0;
      rx_done = 1'b0;
      rx_data = 8'h00;
      idle(3);
      check("rst_pulse", 32'(pulse), 32'd0);
      check("rst_mode", 32'(mode), 32'd0);
      check("rst_arg", 32'(arg_data), 32'd0);
      check("rst_valid", 32'(arg_valid), 32'd0);
      check("rst_err", 32'(cmd_err), 32'd0);
      rst = 1'b1;
      idle(1);

      // Back-to-back pulses, stretched to 3 cycles each
      drive(8'h55);
      check("ud_c1", 32'(pulse), 32'h01);
      drive(8'h44);
      check("ud_c2", 32'(pulse), 32'h03);
      idle(1);
      check("ud_c3", 32'(pulse), 32'h03);
      idle(1);
      check("ud_c4", 32'(pulse), 32'h02);
      idle(1);
      check("ud_c5", 32'(pulse), 32'h00);

      // Mode toggles
      drive(8'h4D);
      check("mode_m1", 32'(mode), 32'h01);
      drive(8'h4D);
      check("mode_m2", 32'(mode), 32'h00);
      drive(8'h54);
      check("mode_t", 32'(mode), 32'h04);
      check("mode_t_err", 32'(cmd_err), 32'd0);
      drive(8'h4D);
      drive(8'h4D);
      check("mode_mm", 32'(mode), 32'h04);

      // Argument 123
      drive(8'h56); drive(8'h31); drive(8'h32); drive(8'h33);
      check("arg_busy_valid", 32'(arg_valid), 32'd0);
      drive(8'h0D);
      check("arg123_valid", 32'(arg_valid), 32'd1);
      check("arg123_data", 32'(arg_data), 32'd123);
      check("arg123_err", 32'(cmd_err), 32'd0);
      idle(1);
      check("arg123_strobe", 32'(arg_valid), 32'd0);

      // Timeout: after the last byte, 50 idle edges expire the argument
      drive(8'h56); drive(8'h34);
      err_seen  = 0;
      err_first = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (cmd_err) begin
            err_seen++;
            if (err_first == 0) err_first = i;
         end
      end
      check("tmo_count", 32'(err_seen), 32'd1);
      check("tmo_cycle", 32'(err_first), 32'd50);
      check("tmo_arg", 32'(arg_data), 32'd123);
      drive(8'h55);
      check("tmo_idle_u", 32'(pulse), 32'h01);
      idle(3);

      // Saturating argument
      drive(8'h56); drive(8'h39); drive(8'h39); drive(8'h39); drive(8'h39);
      drive(8'h0D);
      check("sat_valid", 32'(arg_valid), 32'd1);
      check("sat_data", 32'(arg_data), 32'd1023);

      // ESC aborts the argument without error
      drive(8'h56); drive(8'h35); drive(8'h1B);
      check("esc_pulse", 32'(pulse), 32'h80);
      check("esc_err", 32'(cmd_err), 32'd0);
      check("esc_arg", 32'(arg_data), 32'd1023);
      check("esc_mode", 32'(mode), 32'h04);
      idle(3);

      // Empty argument
      drive(8'h56); drive(8'h0D);
      check("vcr_err", 32'(cmd_err), 32'd1);
      check("vcr_valid", 32'(arg_valid), 32'd0);

      // Unknown byte inside argument is not reinterpreted
      drive(8'h56); drive(8'h58);
      check("vx_err", 32'(cmd_err), 32'd1);
      check("vx_mode", 32'(mode), 32'h04);
      check("vx_pulse", 32'(pulse), 32'h00);
      drive(8'h55);
      check("vx_then_u", 32'(pulse), 32'h01);
      check("vx_then_u_err", 32'(cmd_err), 32'd0);
      drive(8'h58);
      check("idle_x_err", 32'(cmd_err), 32'd1);
      idle(3);

      // Lowercase handling
      drive(8'h75);
`ifdef UART_CMD_CASE_FOLD_EN
      check("lc_u_pulse", 32'(pulse), 32'h01);
      check("lc_u_err", 32'(cmd_err), 32'd0);
`else
      check("lc_u_pulse", 32'(pulse), 32'h00);
      check("lc_u_err", 32'(cmd_err), 32'd1);
`endif
      idle(3);

      // Reset mid-argument, with a command byte arriving on the reset cycle
      drive(8'h56); drive(8'h37);
      rst     = 1'b0;
      rx_done = 1'b1;
      rx_data = 8'h55;
      @(negedge clk);
      rx_done = 1'b0;
      check("mrst_pulse", 32'(pulse), 32'd0);
      check("mrst_mode", 32'(mode), 32'd0);
      check("mrst_arg", 32'(arg_data), 32'd0);
      check("mrst_valid", 32'(arg_valid), 32'd0);
      check("mrst_err", 32'(cmd_err), 32'd0);
      rst = 1'b1;
      idle(1);
      drive(8'h0D);
      check("mrst_cr_err", 32'(cmd_err), 32'd1);
      check("mrst_cr_valid", 32'(arg_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
